// File: rtl/fp_dot_product_acc.sv
// ---------------------------------------------------------------------------
// fp_dot_product_acc
//   Streaming floating-point dot product with vector accumulation.
//   Each accepted beat carries NUM_INPUTS lanes of a/b operands. The lanes are
//   multiplied by an external shared multiplier (fixed MULT_LATENCY). The
//   products, masked by the lane enables and joined by a bias lane (c on the
//   first beat of a vector), are summed by an internal adder tree. Per-beat
//   partial sums queue in a FIFO, and an accumulator FSM folds them together
//   through an external shared adder (fixed SUM_LATENCY) until the last beat,
//   then presents the result on out/out_valid until out_ready.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_ready             beat handshake
//   in_first/in_last              vector boundary tags of the beat
//   a, b                          WIDTH*NUM_INPUTS operand lanes
//   enable                        per-lane product mask
//   c                             bias, added on the first beat only
//   out/out_valid/out_ready       result handshake
//   vector_mult_*                 shared multiplier request/response
//   acc_add_*                     shared adder request/response
//
// Optional build macro
//   FP_DOT_ACC_BEAT_COUNT_EN      adds out_beats[7:0]: beats folded into the
//                                 current result, saturating at 255.
//
// Floating-point adds inside the tree flush subnormals to zero, round to
// nearest-even and do not special-case infinities or NaNs.
// ---------------------------------------------------------------------------

module fp_adder_tree #(
    parameter int WIDTH    = 32,
    parameter int N        = 6,
    parameter int USER_W   = 2,
    parameter int PIPELINE = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_valid,
    input  logic [USER_W-1:0]   i_user,
    input  logic [WIDTH*N-1:0]  i_data,
    output logic                o_valid,
    output logic [USER_W-1:0]   o_user,
    output logic [WIDTH-1:0]    o_data
);
    localparam int EXP_W  = (WIDTH == 64) ? 11 : (WIDTH == 16) ? 5 : 8;
    localparam int MAN_W  = WIDTH - 1 - EXP_W;
    localparam int SW     = MAN_W + 5;  // carry, hidden, mantissa, guard/round/sticky
    localparam int LEVELS = (N <= 1) ? 1 : $clog2(N);
    localparam int NT     = 1 << LEVELS;

    function automatic logic [WIDTH-1:0] fp_add(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0]   p, q, t;
        logic [SW-1:0]      mp, mq, sh, s, mask;
        logic [MAN_W+1:0]   mr;
        logic               rup;
        int                 d, e;
        p = x;
        q = y;
        if (q[WIDTH-2:0] > p[WIDTH-2:0]) begin
            t = p; p = q; q = t;
        end
        if (p[WIDTH-2:MAN_W] == '0) return '0;
        mp = {2'b01, p[MAN_W-1:0], 3'b000};
        mq = (q[WIDTH-2:MAN_W] == '0) ? '0 : {2'b01, q[MAN_W-1:0], 3'b000};
        d  = int'(p[WIDTH-2:MAN_W]) - int'(q[WIDTH-2:MAN_W]);
        if (d > SW) d = SW;
        // Bits shifted out of the smaller operand collapse into the sticky bit.
        mask  = (SW'(1) << d) - SW'(1);
        sh    = mq >> d;
        sh[0] = sh[0] | (|(mq & mask));
        s = (p[WIDTH-1] == q[WIDTH-1]) ? mp + sh : mp - sh;
        if (s == '0) return '0;
        e = int'(p[WIDTH-2:MAN_W]);
        if (s[SW-1]) begin
            s = {1'b0, s[SW-1:2], s[1] | s[0]};
            e = e + 1;
        end else begin
            for (int i = 0; i < SW - 2; i++) begin
                if (!s[SW-2]) begin
                    s = s << 1;
                    e = e - 1;
                end
            end
        end
        if (e <= 0) return {p[WIDTH-1], {(WIDTH-1){1'b0}}};
        rup = s[2] & (s[1] | s[0] | s[3]);
        mr  = {1'b0, s[SW-2:3]} + {{(MAN_W+1){1'b0}}, rup};
        if (mr[MAN_W+1]) e = e + 1;
        if (e >= (1 << EXP_W) - 1) return {p[WIDTH-1], {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        return {p[WIDTH-1], EXP_W'(e), mr[MAN_W+1] ? mr[MAN_W:1] : mr[MAN_W-1:0]};
    endfunction

    logic [WIDTH-1:0]  w_node [0:LEVELS][0:NT-1];
    logic              w_vld  [0:LEVELS];
    logic [USER_W-1:0] w_user [0:LEVELS];

    assign w_vld[0]  = i_valid;
    assign w_user[0] = i_user;

    for (genvar j = 0; j < NT; j++) begin : g_in
        if (j < N) begin : g_lane
            assign w_node[0][j] = i_data[j*WIDTH +: WIDTH];
        end else begin : g_zero
            assign w_node[0][j] = '0;
        end
    end

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int NN = NT >> (k + 1);
        for (genvar j = 0; j < NT; j++) begin : g_node
            if (j < NN) begin : g_add
                logic [WIDTH-1:0] w_sum;
                assign w_sum = fp_add(w_node[k][2*j], w_node[k][2*j+1]);
                if (PIPELINE != 0) begin : g_reg
                    logic [WIDTH-1:0] r_sum;
                    always_ff @(posedge clk) r_sum <= w_sum;
                    assign w_node[k+1][j] = r_sum;
                end else begin : g_comb
                    assign w_node[k+1][j] = w_sum;
                end
            end else begin : g_pad
                assign w_node[k+1][j] = '0;
            end
        end
        if (PIPELINE != 0) begin : g_vreg
            logic              r_vld;
            logic [USER_W-1:0] r_user;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_vld  <= 1'b0;
                    r_user <= '0;
                end else begin
                    r_vld  <= w_vld[k];
                    r_user <= w_user[k];
                end
            end
            assign w_vld[k+1]  = r_vld;
            assign w_user[k+1] = r_user;
        end else begin : g_vcomb
            assign w_vld[k+1]  = w_vld[k];
            assign w_user[k+1] = w_user[k];
        end
    end

    assign o_valid = w_vld[LEVELS];
    assign o_user  = w_user[LEVELS];
    assign o_data  = w_node[LEVELS][0];
endmodule

module fp_dot_product_acc #(
    parameter int WIDTH               = 32,
    parameter int NUM_INPUTS          = 5,
    parameter int MULT_LATENCY        = 8,
    parameter int SUM_LATENCY         = 11,
    parameter int PIPELINE_ADDER_TREE = 1,
    parameter int FIFO_DEPTH          = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_first,
    input  logic                        in_last,
    input  logic [WIDTH*NUM_INPUTS-1:0] a,
    input  logic [WIDTH*NUM_INPUTS-1:0] b,
    input  logic [NUM_INPUTS-1:0]       enable,
    input  logic [WIDTH-1:0]            c,
    output logic [WIDTH-1:0]            out,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH*NUM_INPUTS-1:0] vector_mult_in_a,
    output logic [WIDTH*NUM_INPUTS-1:0] vector_mult_in_b,
    output logic                        vector_mult_in_ready,
    input  logic [WIDTH*NUM_INPUTS-1:0] vector_mult_out,
    input  logic                        vector_mult_out_valid,
    output logic [WIDTH-1:0]            acc_add_a,
    output logic [WIDTH-1:0]            acc_add_b,
    output logic                        acc_add_ready,
    input  logic [WIDTH-1:0]            acc_add_out,
    input  logic                        acc_add_valid
`ifdef FP_DOT_ACC_BEAT_COUNT_EN
    ,
    output logic [7:0]                  out_beats
`endif
);
    localparam int M  = MULT_LATENCY;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_OUT} state_t;

    logic                  w_in_ready, w_accept, w_pop, w_empty;
    logic [CW-1:0]         r_credits;
    logic                  r_dly_vld   [0:M];
    logic                  r_dly_first [0:M];
    logic                  r_dly_last  [0:M];
    logic [NUM_INPUTS-1:0] r_dly_en    [0:M];
    logic [WIDTH-1:0]      r_dly_c     [0:M];
    logic [WIDTH*NUM_INPUTS-1:0] r_prod;
    logic [WIDTH-1:0]      w_bias, w_tree_data;
    logic                  w_tree_vld;
    logic [1:0]            w_tree_tag;
    logic [WIDTH-1:0]      r_fifo_data [0:FIFO_DEPTH-1];
    logic [1:0]            r_fifo_tag  [0:FIFO_DEPTH-1];
    logic [AW:0]           r_wr_ptr, r_rd_ptr;
    logic [WIDTH-1:0]      w_head_data;
    logic                  w_head_first, w_head_last;
    state_t                r_state, w_state_next;
    logic [WIDTH-1:0]      r_acc;
    logic                  r_pend_last;

    // Input handshake; in_ready held low while rst is asserted.
    assign w_in_ready           = !rst && (r_credits < CW'(FIFO_DEPTH));
    assign in_ready             = w_in_ready;
    assign w_accept             = in_valid && w_in_ready;
    assign vector_mult_in_ready = w_accept;
    assign vector_mult_in_a     = a;
    assign vector_mult_in_b     = b;

    // Sideband delay line: stage i holds a beat accepted i+1 cycles ago.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= M; i++) begin
                r_dly_vld[i]   <= 1'b0;
                r_dly_first[i] <= 1'b0;
                r_dly_last[i]  <= 1'b0;
                r_dly_en[i]    <= '0;
            end
        end else begin
            r_dly_vld[0]   <= w_accept;
            r_dly_first[0] <= in_first;
            r_dly_last[0]  <= in_last;
            r_dly_en[0]    <= enable;
            for (int i = 1; i <= M; i++) begin
                r_dly_vld[i]   <= r_dly_vld[i-1];
                r_dly_first[i] <= r_dly_first[i-1];
                r_dly_last[i]  <= r_dly_last[i-1];
                r_dly_en[i]    <= r_dly_en[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        r_dly_c[0] <= c;
        for (int i = 1; i <= M; i++) r_dly_c[i] <= r_dly_c[i-1];
    end

    // Products arrive M cycles after accept, so they are masked with the
    // enable from stage M-1 and line up with the tags in stage M.
    always_ff @(posedge clk) begin
        if (vector_mult_out_valid) begin
            for (int i = 0; i < NUM_INPUTS; i++)
                r_prod[i*WIDTH +: WIDTH] <= r_dly_en[M-1][i] ? vector_mult_out[i*WIDTH +: WIDTH] : '0;
        end
    end

    assign w_bias = r_dly_first[M] ? r_dly_c[M] : '0;

    fp_adder_tree #(
        .WIDTH    (WIDTH),
        .N        (NUM_INPUTS + 1),
        .USER_W   (2),
        .PIPELINE (PIPELINE_ADDER_TREE)
    ) u_tree (
        .clk     (clk),
        .rst     (rst),
        .i_valid (r_dly_vld[M]),
        .i_user  ({r_dly_last[M], r_dly_first[M]}),
        .i_data  ({w_bias, r_prod}),
        .o_valid (w_tree_vld),
        .o_user  (w_tree_tag),
        .o_data  (w_tree_data)
    );

    // Partial-sum FIFO; credits guarantee a free slot for every in-flight beat.
    assign w_empty      = (r_wr_ptr == r_rd_ptr);
    assign w_head_data  = r_fifo_data[r_rd_ptr[AW-1:0]];
    assign w_head_first = r_fifo_tag[r_rd_ptr[AW-1:0]][0];
    assign w_head_last  = r_fifo_tag[r_rd_ptr[AW-1:0]][1];

    always_ff @(posedge clk) begin
        if (w_tree_vld) begin
            r_fifo_data[r_wr_ptr[AW-1:0]] <= w_tree_data;
            r_fifo_tag[r_wr_ptr[AW-1:0]]  <= w_tree_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_credits <= '0;
        end else begin
            if (w_tree_vld) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)      r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_accept, w_pop})
                2'b10:   r_credits <= r_credits + 1'b1;
                2'b01:   r_credits <= r_credits - 1'b1;
                default: r_credits <= r_credits;
            endcase
        end
    end

    // Accumulator FSM.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next  = r_state;
        w_pop         = 1'b0;
        acc_add_ready = 1'b0;
        acc_add_a     = r_acc;
        acc_add_b     = w_head_data;
        if (!rst) begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        w_pop = 1'b1;
                        if (w_head_first) begin
                            w_state_next = w_head_last ? S_OUT : S_IDLE;
                        end else begin
                            acc_add_ready = 1'b1;
                            w_state_next  = S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (acc_add_valid) w_state_next = r_pend_last ? S_OUT : S_IDLE;
                end
                S_OUT: begin
                    if (out_ready) w_state_next = S_IDLE;
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)        r_pend_last <= 1'b0;
        else if (w_pop) r_pend_last <= w_head_last;
    end

    always_ff @(posedge clk) begin
        if (w_pop && w_head_first)                 r_acc <= w_head_data;
        else if (r_state == S_WAIT && acc_add_valid) r_acc <= acc_add_out;
    end

    assign out       = r_acc;
    assign out_valid = (r_state == S_OUT);

`ifdef FP_DOT_ACC_BEAT_COUNT_EN
    logic [7:0] r_beats;
    always_ff @(posedge clk) begin
        if (rst)
            r_beats <= 8'd0;
        else if (w_pop)
            r_beats <= w_head_first ? 8'd1 : ((r_beats == 8'hFF) ? r_beats : r_beats + 8'd1);
    end
    assign out_beats = r_beats;
`endif
endmodule

// File: tb/tb_fp_dot_product_acc.sv
module tb_fp_dot_product_acc;
    localparam int W   = 32;
    localparam int N   = 5;
    localparam int ML  = 8;
    localparam int SL  = 11;
    localparam int FD  = 16;
    localparam int LAT = ML + 1 + 3 + 2;  // three registered tree levels for six inputs

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0, out_ready = 1'b1;
    logic [W*N-1:0] a = '0, b = '0;
    logic [N-1:0] enable = '0;
    logic [W-1:0] c = '0;
    logic in_ready, out_valid, vector_mult_in_ready, vector_mult_out_valid;
    logic acc_add_ready, acc_add_valid;
    logic [W-1:0] out, acc_add_a, acc_add_b, acc_add_out;
    logic [W*N-1:0] vector_mult_in_a, vector_mult_in_b, vector_mult_out;
`ifdef FP_DOT_ACC_BEAT_COUNT_EN
    logic [7:0] out_beats;
    logic [7:0] last_beats = '0;
`endif

    always #5 clk = ~clk;

    fp_dot_product_acc dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first), .in_last(in_last),
        .a(a), .b(b), .enable(enable), .c(c),
        .out(out), .out_valid(out_valid), .out_ready(out_ready),
        .vector_mult_in_a(vector_mult_in_a), .vector_mult_in_b(vector_mult_in_b),
        .vector_mult_in_ready(vector_mult_in_ready), .vector_mult_out(vector_mult_out),
        .vector_mult_out_valid(vector_mult_out_valid),
        .acc_add_a(acc_add_a), .acc_add_b(acc_add_b), .acc_add_ready(acc_add_ready),
        .acc_add_out(acc_add_out), .acc_add_valid(acc_add_valid)
`ifdef FP_DOT_ACC_BEAT_COUNT_EN
        , .out_beats(out_beats)
`endif
    );

    // fp32 <-> real, exact for the normal values used here.
    function automatic real f2r(input logic [31:0] x);
        logic [63:0] d;
        if (x[30:23] == 8'd0) return 0.0;
        d = {x[31], 11'(int'(x[30:23]) - 127 + 1023), x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        d = $realtobits(r);
        if (d[62:52] == 11'd0) return 32'h0;
        return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
    endfunction

    function automatic logic [W*N-1:0] bcast(input logic [31:0] x);
        return {N{x}};
    endfunction

    function automatic logic [W*N-1:0] vmul(input logic [W*N-1:0] x, input logic [W*N-1:0] y);
        logic [W*N-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = r2f(f2r(x[i*W +: W]) * f2r(y[i*W +: W]));
        return r;
    endfunction

    // Shared multiplier and shared adder: fixed-latency pipelines, not reset.
    logic [W*N-1:0] mq_d [0:ML-1];
    logic           mq_v [0:ML-1] = '{default: 1'b0};
    logic [W-1:0]   ad_d [0:SL-1];
    logic           ad_v [0:SL-1] = '{default: 1'b0};
    int add_uses = 0;

    always @(posedge clk) begin
        mq_v[0] <= vector_mult_in_ready;
        mq_d[0] <= vmul(vector_mult_in_a, vector_mult_in_b);
        for (int i = 1; i < ML; i++) begin
            mq_v[i] <= mq_v[i-1];
            mq_d[i] <= mq_d[i-1];
        end
        ad_v[0] <= acc_add_ready;
        ad_d[0] <= r2f(f2r(acc_add_a) + f2r(acc_add_b));
        for (int i = 1; i < SL; i++) begin
            ad_v[i] <= ad_v[i-1];
            ad_d[i] <= ad_d[i-1];
        end
        if (acc_add_ready) add_uses <= add_uses + 1;
    end
    assign vector_mult_out       = mq_d[ML-1];
    assign vector_mult_out_valid = mq_v[ML-1];
    assign acc_add_out           = ad_d[SL-1];
    assign acc_add_valid         = ad_v[SL-1];

    int tests = 0, fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: sums per vector in plain real arithmetic.
    logic [31:0] expq[$];
    logic [31:0] exp_last = '0;
    real macc = 0.0;
    int acc_cyc = 0;

    // Compare process.
    logic [31:0] last_out = '0, prev_out = '0;
    logic prev_ov = 1'b0, prev_or = 1'b0;
    int rise_cyc = 0, n_out = 0;

    always @(negedge clk) begin
        if (rst) begin
            prev_ov = 1'b0;
            prev_or = 1'b0;
        end else begin
            if (out_valid && prev_ov && !prev_or) chk("out_stable", out, prev_out);
            if (out_valid && !prev_ov) rise_cyc = cyc;
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_out: got %h, expected no result", out);
                end else begin
                    chk("out_vs_model", out, expq.pop_front());
                end
                last_out = out;
`ifdef FP_DOT_ACC_BEAT_COUNT_EN
                last_beats = out_beats;
`endif
                n_out++;
            end
            prev_ov  = out_valid;
            prev_or  = out_ready;
            prev_out = out;
        end
    end

    task automatic send_beat(input logic f, input logic l, input logic [N-1:0] en,
                             input logic [W*N-1:0] av, input logic [W*N-1:0] bv,
                             input logic [31:0] cv, input int limit, output bit ok);
        int g;
        real part;
        in_valid = 1'b1; in_first = f; in_last = l; enable = en; a = av; b = bv; c = cv;
        ok = 1'b0;
        g = 0;
        while (!ok && g < limit) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                acc_cyc = cyc;
            end
            @(posedge clk);
            #1;
            g++;
        end
        in_valid = 1'b0;
        if (ok) begin
            part = f ? f2r(cv) : 0.0;
            for (int i = 0; i < N; i++)
                if (en[i]) part += f2r(av[i*W +: W]) * f2r(bv[i*W +: W]);
            macc = f ? part : macc + part;
            if (l) begin
                exp_last = r2f(macc);
                expq.push_back(exp_last);
            end
        end
    endtask

    task automatic send(input logic f, input logic l, input logic [N-1:0] en,
                        input logic [W*N-1:0] av, input logic [W*N-1:0] bv, input logic [31:0] cv);
        bit ok;
        send_beat(f, l, en, av, bv, cv, 200, ok);
        if (!ok) chk("accept_timeout", 64'(ok), 64'd1);
    endtask

    task automatic drain();
        int g = 0;
        while (expq.size() != 0 && g < 1000) begin
            @(posedge clk);
            g++;
        end
        chk("drain_done", 64'(expq.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] ONE = 32'h3F800000, TWO = 32'h40000000;

    initial begin
        int au0, n0, nacc, g;
        bit ok;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_acc_add_ready", 64'(acc_add_ready), 64'd0);
        chk("rst_mult_in_ready", 64'(vector_mult_in_ready), 64'd0);
        @(posedge clk);
        #1;

        // Single beat, all lanes: 5*2 + 1 = 11.
        send(1'b1, 1'b1, 5'b11111, bcast(ONE), bcast(TWO), ONE);
        chk("model_single", exp_last, 32'h41300000);
        drain();
        chk("single_out", last_out, 32'h41300000);
        chk("single_latency", 64'(rise_cyc - acc_cyc), 64'(LAT));

        // Masked lanes 0 and 2: 2*2 + 1 = 5.
        au0 = add_uses;
        send(1'b1, 1'b1, 5'b00101, bcast(ONE), bcast(TWO), ONE);
        chk("model_mask", exp_last, 32'h40A00000);
        drain();
        chk("mask_out", last_out, 32'h40A00000);
        chk("single_no_adder", 64'(add_uses - au0), 64'd0);

        // Three-beat vector: 11 + 10 + 10 = 31, two shared adds.
        au0 = add_uses;
        send(1'b1, 1'b0, 5'b11111, bcast(ONE), bcast(TWO), ONE);
        send(1'b0, 1'b0, 5'b11111, bcast(ONE), bcast(TWO), ONE);
        send(1'b0, 1'b1, 5'b11111, bcast(ONE), bcast(TWO), ONE);
        chk("model_three", exp_last, 32'h41F80000);
        drain();
        chk("three_out", last_out, 32'h41F80000);
        chk("three_adds", 64'(add_uses - au0), 64'd2);
`ifdef FP_DOT_ACC_BEAT_COUNT_EN
        chk("three_beats", 64'(last_beats), 64'd3);
`endif

        // Two beats, different masks: (2+1) + (2+2) = 7.
        au0 = add_uses;
        send(1'b1, 1'b0, 5'b00001, bcast(ONE), bcast(TWO), ONE);
        send(1'b0, 1'b1, 5'b11000, bcast(ONE), bcast(TWO), ONE);
        chk("model_two", exp_last, 32'h40E00000);
        drain();
        chk("two_out", last_out, 32'h40E00000);
        chk("two_adds", 64'(add_uses - au0), 64'd1);

        // Distinct lanes 1..5 times 0.5 with bias -10: 7.5 - 10 = -2.5.
        send(1'b1, 1'b1, 5'b11111,
             {32'h40A00000, 32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000},
             bcast(32'h3F000000), 32'hC1200000);
        chk("model_neg", exp_last, 32'hC0200000);
        drain();
        chk("neg_out", last_out, 32'hC0200000);

        // Backpressure: results held, beats with bias k give 10+k in order.
        out_ready = 1'b0;
        n0 = n_out;
        nacc = 0;
        for (int k = 1; k <= 20; k++) begin
            send_beat(1'b1, 1'b1, 5'b11111, bcast(ONE), bcast(TWO), r2f(real'(k)), 40, ok);
            if (!ok) break;
            nacc++;
        end
        chk("bp_accepted", 64'(nacc), 64'(FD + 1));
        @(negedge clk);
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        chk("bp_held_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1 out_ready = 1'b1;
        drain();
        chk("bp_outputs", 64'(n_out - n0), 64'(FD + 1));
        chk("bp_last", last_out, 32'h41D80000);  // 10 + 17 = 27

        // Reset while waiting on the shared adder, with later beats in flight.
        for (int k = 0; k < 6; k++)
            send(k == 0, k == 5, 5'b11111, bcast(ONE), bcast(TWO), ONE);
        g = 0;
        while (g < 200) begin
            @(negedge clk);
            if (acc_add_ready) break;
            g++;
        end
        chk("rst_test_issue_seen", 64'(g < 200), 64'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        expq.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        n0 = n_out;
        @(negedge clk);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        repeat (40) @(posedge clk);
        #1;
        chk("midrst_no_output", 64'(n_out - n0), 64'd0);
        send(1'b1, 1'b1, 5'b11111, bcast(ONE), bcast(TWO), ONE);
        drain();
        chk("post_rst_out", last_out, 32'h41300000);
        chk("post_rst_count", 64'(n_out - n0), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
